mapper_init_seq: RTL and testbench

MAPPER_INIT_SEQ -- requirements
Module: mapper_init_seq

---
 rtl/mapper_init_seq.sv | 144 ++++++++++++++
 tb/tb_mapper_init_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_init_seq.sv
// mapper_init_seq: unlocks a cartridge mapper, checks its 18-bit ID stream, then
// writes and reads back the four bank registers C0h..C3h.
module mapper_init_seq #(
    parameter logic [7:0] LAO_VAL  = 8'h00,
    parameter logic [7:0] RAM_VAL  = 8'h00,
    parameter logic [7:0] ROM0_VAL = 8'h00,
    parameter logic [7:0] ROM1_VAL = 8'h00
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       START,
    input  logic       SO,
    input  logic [7:0] DQ_IN,
    output logic [7:0] ADDR,
    output logic [7:0] DQ_OUT,
    output logic       DQ_OE,
    output logic       CEn,
    output logic       OEn,
    output logic       WEn,
    output logic       SSn,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [1:0] ERR_CODE
);
    localparam logic [17:0] MAGIC = 18'h05140;

    typedef enum logic [3:0] {
        IDLE, UNLK_ACK, UNLK_NAK, CAPTURE, WR_SETUP, WR_STROBE,
        WR_HOLD, RD_DRIVE, RD_SAMPLE, DONE_ST, ERR_ST
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  n_q, n_d, err_code_q, err_code_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [17:0] cap_q, cap_d;
    logic [7:0]  addr_q, addr_d, dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, wr, rd;

    function automatic logic [7:0] bank_val(input logic [1:0] i);
        return i == 2'd0 ? LAO_VAL : i == 2'd1 ? RAM_VAL : i == 2'd2 ? ROM0_VAL : ROM1_VAL;
    endfunction

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE:      state_d = START ? UNLK_ACK : IDLE;
            UNLK_ACK:  state_d = UNLK_NAK;
            UNLK_NAK: begin
                state_d = CAPTURE;
                cnt_d   = 5'd0;
            end
            CAPTURE: begin
                cap_d = {SO, cap_q[17:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd17) begin
                    state_d    = cap_d == MAGIC ? WR_SETUP : ERR_ST;
                    err_code_d = cap_d == MAGIC ? err_code_q : 2'b01;
                    n_d        = 2'd0;
                end
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: state_d = WR_HOLD;
            WR_HOLD:   state_d = RD_DRIVE;
            RD_DRIVE:  state_d = RD_SAMPLE;
            RD_SAMPLE: begin
                state_d    = DQ_IN != bank_val(n_q) ? ERR_ST : n_q == 2'd3 ? DONE_ST : WR_SETUP;
                err_code_d = DQ_IN != bank_val(n_q) ? 2'b10 : err_code_q;
                n_d        = DQ_IN == bank_val(n_q) && n_q != 2'd3 ? n_q + 2'd1 : n_q;
            end
            // the mapper stays unlocked, so a rerun goes straight to the bank writes
            DONE_ST: begin
                state_d = START ? WR_SETUP : DONE_ST;
                n_d     = START ? 2'd0 : n_q;
            end
            ERR_ST:    state_d = ERR_ST;
            default:   state_d = IDLE;
        endcase
        wr       = state_d inside {WR_SETUP, WR_STROBE, WR_HOLD};
        rd       = state_d inside {RD_DRIVE, RD_SAMPLE};
        addr_d   = state_d == UNLK_ACK ? 8'h5A : state_d == UNLK_NAK ? 8'hA5 :
                   (wr || rd) ? {6'b110000, n_d} : 8'hFF;
        dq_out_d = wr ? bank_val(n_d) : 8'h00;
        dq_oe_d  = wr;
        ce_n_d   = !(wr || rd);
        oe_n_d   = !rd;
        we_n_d   = state_d != WR_STROBE;
        busy_d   = !(state_d inside {IDLE, DONE_ST, ERR_ST});
        done_d   = state_d == DONE_ST;
        err_d    = state_d == ERR_ST;
    end

    // outputs are registered from the next state so they line up with state_q
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            n_q        <= 2'd0;
            cnt_q      <= 5'd0;
            cap_q      <= '1;
            err_code_q <= 2'b00;
            addr_q     <= 8'hFF;
            dq_out_q   <= 8'h00;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            err_code_q <= err_code_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ADDR     = addr_q;
    assign DQ_OUT   = dq_out_q;
    assign DQ_OE    = dq_oe_q;
    assign CEn      = ce_n_q;
    assign OEn      = oe_n_q;
    assign WEn      = we_n_q;
    assign SSn      = 1'b1;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CODE = err_code_q;
endmodule

// File: tb/tb_mapper_init_seq.sv
// tb_mapper_init_seq: drives mapper_init_seq against a behavioural cartridge model
// and compares bus traces with sequences derived from the protocol rules.
module tb_mapper_init_seq;
    localparam logic [7:0] P0 = 8'h3C, P1 = 8'h81, P2 = 8'h5E, P3 = 8'hA7;

    typedef logic [7:0] bq_t[$];

    logic       CLK = 1'b0, RSTn = 1'b0, START = 1'b0, SO = 1'b0;
    logic [7:0] DQ_IN, ADDR, DQ_OUT;
    logic       DQ_OE, CEn, OEn, WEn, SSn, BUSY, DONE, ERR;
    logic [1:0] ERR_CODE;

    int   total = 0, bad = 0, viol = 0, so_idx = 18;
    bit   corrupt = 0, bad_rd = 0;
    logic [7:0] mem [4];
    logic [7:0] addr_tr[$];
    bit         we_tr[$], busy_tr[$];

    mapper_init_seq #(.LAO_VAL(P0), .RAM_VAL(P1), .ROM0_VAL(P2), .ROM1_VAL(P3)) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .SO(SO), .DQ_IN(DQ_IN),
        .ADDR(ADDR), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .CEn(CEn), .OEn(OEn),
        .WEn(WEn), .SSn(SSn), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] pval(input int n);
        return n == 0 ? P0 : n == 1 ? P1 : n == 2 ? P2 : P3;
    endfunction

    // cartridge model: bank registers echo writes; reads of C2h can be forced to FFh
    always @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'($urandom);
        end else if (!CEn && !WEn && ADDR[7:2] == 6'b110000) begin
            mem[ADDR[1:0]] <= DQ_OUT;
        end
    end

    assign DQ_IN = (!OEn && ADDR[7:2] == 6'b110000) ?
                   ((bad_rd && ADDR[1:0] == 2'd2) ? 8'hFF : mem[ADDR[1:0]]) : 8'h00;

    // ID stream: bit i of 05140h is presented in the i-th cycle after the A5h byte
    always @(negedge CLK) begin
        logic [17:0] stream;
        stream = 18'h05140 ^ (corrupt ? 18'h00020 : 18'h0);
        if (ADDR == 8'hA5) begin
            so_idx = 0;
            SO = 1'($urandom);
        end else if (so_idx < 18) begin
            SO = stream[so_idx];
            so_idx++;
        end else begin
            SO = 1'($urandom);
        end
    end

    always @(negedge CLK) if ((DQ_OE && !OEn) || !SSn) viol++;

    function automatic bq_t exp_addr(input bit unlock);
        bq_t q;
        if (unlock) begin
            q.push_back(8'h5A);
            q.push_back(8'hA5);
            repeat (18) q.push_back(8'hFF);
        end
        for (int n = 0; n < 4; n++) repeat (5) q.push_back(8'hC0 + 8'(n));
        q.push_back(8'hFF);
        return q;
    endfunction

    function automatic int count_addr(input logic [7:0] a);
        int c = 0;
        foreach (addr_tr[i]) if (addr_tr[i] == a) c++;
        return c;
    endfunction

    function automatic int count_we_low();
        int c = 0;
        foreach (we_tr[i]) if (!we_tr[i]) c++;
        return c;
    endfunction

    task automatic do_reset();
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    // cyc 0 is the sample just after the edge that takes START
    task automatic run_seq(input int budget, input int inj_cyc, output int done_cyc, output int err_cyc);
        addr_tr.delete(); we_tr.delete(); busy_tr.delete();
        done_cyc = -1;
        err_cyc  = -1;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        for (int c = 0; c < budget; c++) begin
            START = (c == inj_cyc);
            addr_tr.push_back(ADDR);
            we_tr.push_back(WEn);
            busy_tr.push_back(BUSY);
            if (DONE) begin done_cyc = c; break; end
            if (ERR) begin err_cyc = c; break; end
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    task automatic check_traces(input string tag, input bit unlock);
        bq_t e = exp_addr(unlock);
        int  off = unlock ? 20 : 0;
        int  ma = 0, mw = 0, mb = 0;
        if (addr_tr.size() != e.size()) ma = 1000;
        else foreach (e[i]) if (addr_tr[i] !== e[i]) ma++;
        total++;
        if (ma != 0) begin bad++; $display("FAIL %s addr_trace: %0d bad cycles, got len %0d want len %0d", tag, ma, addr_tr.size(), e.size()); end
        foreach (we_tr[i]) if (we_tr[i] !== !(i >= off && i < off + 20 && (i - off) % 5 == 1)) mw++;
        total++;
        if (mw != 0 || we_tr.size() != e.size()) begin bad++; $display("FAIL %s we_trace: %0d bad cycles", tag, mw); end
        foreach (busy_tr[i]) if (busy_tr[i] !== (i != e.size() - 1)) mb++;
        total++;
        if (mb != 0) begin bad++; $display("FAIL %s busy_trace: %0d bad cycles", tag, mb); end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (ADDR !== 8'hFF || DQ_OUT !== 8'h00 || DQ_OE !== 1'b0) begin bad++; $display("FAIL reset_bus: addr=%h dq=%h oe=%b want FF 00 0", ADDR, DQ_OUT, DQ_OE); end
        total++;
        if ({CEn, OEn, WEn, SSn} !== 4'hF) begin bad++; $display("FAIL reset_strobes: got %b want 1111", {CEn, OEn, WEn, SSn}); end
        total++;
        if ({BUSY, DONE, ERR, ERR_CODE} !== 5'b0) begin bad++; $display("FAIL reset_status: got %b want 00000", {BUSY, DONE, ERR, ERR_CODE}); end
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_full_run();
        int d, e;
        corrupt = 0; bad_rd = 0;
        do_reset();
        run_seq(100, -1, d, e);
        total++;
        if (d !== 40) begin bad++; $display("FAIL full_done_cycle: got %0d want 40", d); end
        check_traces("full", 1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[i] !== pval(i)) begin bad++; $display("FAIL full_bank%0d: got %h want %h", i, mem[i], pval(i)); end
        end
        total++;
        if ({ERR, ERR_CODE} !== 3'b0) begin bad++; $display("FAIL full_err: got %b want 000", {ERR, ERR_CODE}); end
    endtask

    task automatic test_bitstream_err();
        int d, e;
        corrupt = 1; bad_rd = 0;
        do_reset();
        run_seq(100, -1, d, e);
        corrupt = 0;
        total++;
        if (e !== 20 || d !== -1) begin bad++; $display("FAIL bits_err_cycle: err at %0d done at %0d want 20 -1", e, d); end
        total++;
        if ({ERR, ERR_CODE, BUSY} !== 4'b1010) begin bad++; $display("FAIL bits_err_code: got %b want 1010", {ERR, ERR_CODE, BUSY}); end
        total++;
        if (count_we_low() !== 0) begin bad++; $display("FAIL bits_no_write: got %0d strobes want 0", count_we_low()); end
        repeat (3) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        total++;
        if ({ERR, BUSY, ADDR} !== {2'b10, 8'hFF}) begin bad++; $display("FAIL bits_err_sticky: err=%b busy=%b addr=%h", ERR, BUSY, ADDR); end
    endtask

    task automatic test_readback_err();
        int d, e;
        corrupt = 0; bad_rd = 1;
        do_reset();
        run_seq(100, -1, d, e);
        bad_rd = 0;
        total++;
        if (e !== 35) begin bad++; $display("FAIL rd_err_cycle: got %0d want 35", e); end
        total++;
        if ({ERR, ERR_CODE} !== 3'b110) begin bad++; $display("FAIL rd_err_code: got %b want 110", {ERR, ERR_CODE}); end
        total++;
        if (count_addr(8'hC3) !== 0 || count_we_low() !== 3) begin bad++; $display("FAIL rd_err_c3: c3 cycles %0d writes %0d want 0 3", count_addr(8'hC3), count_we_low()); end
        total++;
        if (mem[0] !== P0 || mem[1] !== P1) begin bad++; $display("FAIL rd_err_good_banks: got %h %h want %h %h", mem[0], mem[1], P0, P1); end
    endtask

    task automatic test_back_to_back();
        int d, e;
        corrupt = 0; bad_rd = 0;
        do_reset();
        run_seq(100, $urandom_range(3, 15), d, e);
        total++;
        if (d !== 40 || count_addr(8'h5A) !== 1) begin bad++; $display("FAIL b2b_capture_start: done %0d unlocks %0d want 40 1", d, count_addr(8'h5A)); end
        check_traces("b2b_first", 1);
        run_seq(100, -1, d, e);
        total++;
        if (d !== 20) begin bad++; $display("FAIL b2b_rerun_cycle: got %0d want 20", d); end
        total++;
        if (count_addr(8'h5A) + count_addr(8'hA5) !== 0) begin bad++; $display("FAIL b2b_no_unlock: got %0d unlock cycles want 0", count_addr(8'h5A) + count_addr(8'hA5)); end
        check_traces("b2b_rerun", 0);
    endtask

    task automatic test_reset_mid_write();
        int bank = $urandom_range(0, 3), idle_bad = 0, d, e;
        corrupt = 0; bad_rd = 0;
        do_reset();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (21 + 5 * bank) @(negedge CLK);
        total++;
        if (WEn !== 1'b0 || ADDR !== 8'hC0 + 8'(bank)) begin bad++; $display("FAIL rst_reach_strobe: we=%b addr=%h want 0 %h", WEn, ADDR, 8'hC0 + 8'(bank)); end
        RSTn = 1'b0;
        #1;
        total++;
        if ({WEn, DQ_OE, BUSY, ADDR} !== {3'b100, 8'hFF}) begin bad++; $display("FAIL rst_abort: we=%b oe=%b busy=%b addr=%h want 1 0 0 FF", WEn, DQ_OE, BUSY, ADDR); end
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (30) begin
            @(negedge CLK);
            if (ADDR !== 8'hFF || !CEn || !OEn || !WEn || BUSY) idle_bad++;
        end
        total++;
        if (idle_bad !== 0) begin bad++; $display("FAIL rst_stays_idle: %0d active cycles want 0", idle_bad); end
        run_seq(100, -1, d, e);
        total++;
        if (d !== 40 || count_addr(8'h5A) !== 1) begin bad++; $display("FAIL rst_fresh_unlock: done %0d unlocks %0d want 40 1", d, count_addr(8'h5A)); end
    endtask

    task automatic test_invariants();
        total++;
        if (viol !== 0) begin bad++; $display("FAIL bus_invariant: %0d cycles with DQ_OE during read or SSn low", viol); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_bitstream_err();
        test_readback_err();
        test_back_to_back();
        test_reset_mid_write();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
